// File: rtl/soc.sv
// soc: single-cycle RV32I-subset core with a unified word memory.
// Define SOC_ILLEGAL_HALT_EN to halt on unsupported opcodes; otherwise they run as NOPs.
module soc_mem #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic [31:0] i_iaddr,
    output logic [31:0] o_idata,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    output logic [31:0] o_rdata
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [31:0]   memory [MEM_WORDS];
    logic [AW-1:0] w_iidx, w_didx;
    logic          w_unused;
    // Dropping the upper address bits gives the modulo-depth wrap.
    assign w_iidx   = i_iaddr[AW+1:2];
    assign w_didx   = i_daddr[AW+1:2];
    assign w_unused = ^{i_iaddr[31:AW+2], i_iaddr[1:0], i_daddr[31:AW+2], i_daddr[1:0]};
    assign o_idata  = memory[w_iidx];
    assign o_rdata  = memory[w_didx];
    always_ff @(posedge clk) begin
        if (i_we) memory[w_didx] <= i_wdata;
    end
endmodule

module soc_rf (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_ra,
    input  logic [4:0]  i_rb,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    input  logic        i_we,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_wd
);
    logic [31:0] registers [32];
    assign o_a = (i_ra == 5'd0) ? 32'd0 : registers[i_ra];
    assign o_b = (i_rb == 5'd0) ? 32'd0 : registers[i_rb];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (i_we && i_rd != 5'd0) begin
            registers[i_rd] <= i_wd;
        end
    end
endmodule

module soc_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_instr,
    input  logic        i_we,
    input  logic [31:0] i_wd,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_imm,
    output logic [2:0]  o_f3,
    output logic        o_sub,
    output logic        o_alu_r,
    output logic        o_alu_i,
    output logic        o_lui,
    output logic        o_auipc,
    output logic        o_load,
    output logic        o_store,
    output logic        o_branch,
    output logic        o_jal,
    output logic        o_jalr,
    output logic        o_illegal
);
    logic [6:0] w_op, w_f7;
    logic       w_f3_alu;
    assign w_op     = i_instr[6:0];
    assign w_f7     = i_instr[31:25];
    assign o_f3     = i_instr[14:12];
    assign w_f3_alu = o_f3 == 3'd0 || o_f3 == 3'd2 || o_f3 == 3'd4 || o_f3 == 3'd6 || o_f3 == 3'd7;
    assign o_alu_r  = w_op == 7'h33 && w_f3_alu && (w_f7 == 7'h00 || (w_f7 == 7'h20 && o_f3 == 3'd0));
    assign o_alu_i  = w_op == 7'h13 && w_f3_alu;
    assign o_lui    = w_op == 7'h37;
    assign o_auipc  = w_op == 7'h17;
    assign o_load   = w_op == 7'h03 && o_f3 == 3'd2;
    assign o_store  = w_op == 7'h23 && o_f3 == 3'd2;
    assign o_branch = w_op == 7'h63 && !o_f3[1];
    assign o_jal    = w_op == 7'h6f;
    assign o_jalr   = w_op == 7'h67 && o_f3 == 3'd0;
    assign o_sub    = o_alu_r && w_f7[5];
    assign o_illegal = !(o_alu_r || o_alu_i || o_lui || o_auipc || o_load || o_store ||
                         o_branch || o_jal || o_jalr);
    assign o_imm = o_store ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
                   o_branch ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                   (o_lui || o_auipc) ? {i_instr[31:12], 12'b0} :
                   o_jal ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                   {{20{i_instr[31]}}, i_instr[31:20]};
    soc_rf RF (
        .clk(clk), .reset(reset),
        .i_ra(i_instr[19:15]), .i_rb(i_instr[24:20]), .o_a(o_a), .o_b(o_b),
        .i_we(i_we), .i_rd(i_instr[11:7]), .i_wd(i_wd)
    );
endmodule

module soc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] o_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_daddr,
    output logic [31:0] o_wdata,
    output logic        o_we,
    input  logic [31:0] i_rdata
);
    logic [31:0] r_pc, w_a, w_b, w_imm, w_op2, w_alu, w_wd, w_pc4, w_pcimm, w_next;
    logic [2:0]  w_f3;
    logic w_sub, w_alu_r, w_alu_i, w_lui, w_auipc, w_load, w_store, w_branch, w_jal, w_jalr;
    logic w_illegal, w_stall, w_rf_we, w_cond;
    soc_decode decode (
        .clk(clk), .reset(reset), .i_instr(i_instr), .i_we(w_rf_we), .i_wd(w_wd),
        .o_a(w_a), .o_b(w_b), .o_imm(w_imm), .o_f3(w_f3), .o_sub(w_sub),
        .o_alu_r(w_alu_r), .o_alu_i(w_alu_i), .o_lui(w_lui), .o_auipc(w_auipc),
        .o_load(w_load), .o_store(w_store), .o_branch(w_branch), .o_jal(w_jal),
        .o_jalr(w_jalr), .o_illegal(w_illegal)
    );
    assign w_op2   = w_alu_r ? w_b : w_imm;
    assign w_alu   = (w_f3 == 3'd0) ? (w_sub ? w_a - w_op2 : w_a + w_op2) :
                     (w_f3 == 3'd2) ? {31'd0, $signed(w_a) < $signed(w_op2)} :
                     (w_f3 == 3'd4) ? w_a ^ w_op2 :
                     (w_f3 == 3'd6) ? w_a | w_op2 : w_a & w_op2;
    // f3[2] picks signed-less-than over equality, f3[0] inverts (BNE/BGE).
    assign w_cond  = (w_f3[2] ? ($signed(w_a) < $signed(w_b)) : (w_a == w_b)) ^ w_f3[0];
    assign w_pc4   = r_pc + 32'd4;
    assign w_pcimm = r_pc + w_imm;
    assign w_next  = w_jalr ? ((w_a + w_imm) & ~32'd1) :
                     ((w_branch && w_cond) || w_jal) ? w_pcimm : w_pc4;
    assign w_wd    = w_lui ? w_imm : w_auipc ? w_pcimm : (w_jal || w_jalr) ? w_pc4 :
                     w_load ? i_rdata : w_alu;
    assign w_rf_we = !reset && !w_stall &&
                     (w_alu_r || w_alu_i || w_lui || w_auipc || w_load || w_jal || w_jalr);
    assign o_we    = !reset && !w_stall && w_store;
    assign o_daddr = w_a + w_imm;
    assign o_wdata = w_b;
    assign o_pc    = r_pc;
`ifdef SOC_ILLEGAL_HALT_EN
    logic r_halt;
    always_ff @(posedge clk) begin
        if (reset) r_halt <= 1'b0;
        else if (w_illegal) r_halt <= 1'b1;
    end
    assign w_stall = r_halt || w_illegal;
`else
    logic w_unused;
    assign w_unused = w_illegal;
    assign w_stall  = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) r_pc <= RESET_PC;
        else if (!w_stall) r_pc <= w_next;
    end
endmodule

module soc #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0200
) (
    input logic clk,
    input logic reset
);
    logic [31:0] w_pc, w_instr, w_daddr, w_wdata, w_rdata;
    logic        w_we;
    soc_core #(.RESET_PC(RESET_PC)) core (
        .clk(clk), .reset(reset), .o_pc(w_pc), .i_instr(w_instr),
        .o_daddr(w_daddr), .o_wdata(w_wdata), .o_we(w_we), .i_rdata(w_rdata)
    );
    soc_mem #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk(clk), .i_iaddr(w_pc), .o_idata(w_instr),
        .i_daddr(w_daddr), .i_wdata(w_wdata), .i_we(w_we), .o_rdata(w_rdata)
    );
endmodule

// File: tb/tb_soc.sv
// tb_soc: directed program tests for soc, checking registers, memory and PC.
// Build with SOC_ILLEGAL_HALT_EN defined to exercise the halting variant.
module tb_soc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] prog [$];

    soc dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rg(input int n);
        return dut.core.decode.RF.registers[n];
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic load_prog();
        for (int k = 0; k < 4096; k++) dut.memory.memory[k] = 32'd0;
        foreach (prog[k]) dut.memory.memory[32'h80 + k] = prog[k];
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic loop_prog();
        prog = '{32'h03200093, 32'h03200113, 32'h001181B3, 32'hFFF10113, 32'hFE011CE3};
    endtask

    task automatic check_loop(input string tag);
        chk({tag, "_x0"}, rg(0), 32'd0);
        chk({tag, "_x1"}, rg(1), 32'h32);
        chk({tag, "_x2"}, rg(2), 32'd0);
        chk({tag, "_x3"}, rg(3), 32'h9C4);
    endtask

    initial begin
        // counting loop
        loop_prog();
        load_prog();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pc", dut.core.r_pc, 32'h200);
        chk("rst_x3", rg(3), 32'd0);
        chk("rst_x31", rg(31), 32'd0);
        reset = 1'b0;
        run(300);
        check_loop("loop");

        // reset mid-program, then rerun
        pulse_reset(1);
        run(20);
        chk("mid_x3", rg(3), 32'h12C);
        chk("mid_x2", rg(2), 32'd44);
        pulse_reset(1);
        chk("rerst_pc", dut.core.r_pc, 32'h200);
        chk("rerst_x3", rg(3), 32'd0);
        run(300);
        check_loop("reloop");

        // store/load, with a reset landing on the store
        prog = '{32'h12300093, 32'h40102023, 32'h40002103};
        load_prog();
        pulse_reset(1);
        run(1);
        chk("sw_pre_x1", rg(1), 32'h123);
        chk("sw_pre_pc", dut.core.r_pc, 32'h204);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("sw_abort_mem", dut.memory.memory[32'h100], 32'd0);
        chk("sw_abort_pc", dut.core.r_pc, 32'h200);
        reset = 1'b0;
        run(3);
        chk("sw_mem", dut.memory.memory[32'h100], 32'h123);
        chk("lw_x2", rg(2), 32'h123);

        // x0 hardwired
        prog = '{32'h00500013, 32'h000000B3};
        load_prog();
        pulse_reset(1);
        run(2);
        chk("x0_zero", rg(0), 32'd0);
        chk("x0_add", rg(1), 32'd0);

        // ALU, branches, JALR, wrap and misaligned load
        prog = '{};
        prog.push_back(enc_i(12'hFFB, 0, 0, 1, 7'h13));
        prog.push_back(enc_i(12'h003, 0, 0, 2, 7'h13));
        prog.push_back(enc_r(7'h20, 2, 1, 0, 3));
        prog.push_back(enc_r(7'h00, 2, 1, 7, 4));
        prog.push_back(enc_r(7'h00, 2, 1, 6, 5));
        prog.push_back(enc_r(7'h00, 2, 1, 4, 6));
        prog.push_back(enc_r(7'h00, 2, 1, 2, 7));
        prog.push_back(enc_r(7'h00, 1, 2, 2, 8));
        prog.push_back(enc_i(12'h0F0, 1, 7, 9, 7'h13));
        prog.push_back(enc_i(12'h700, 2, 6, 10, 7'h13));
        prog.push_back(enc_i(12'hFFF, 2, 4, 11, 7'h13));
        prog.push_back(enc_i(12'hFFC, 1, 2, 12, 7'h13));
        prog.push_back(enc_u(20'h12345, 13, 7'h37));
        prog.push_back(enc_u(20'h00001, 14, 7'h17));
        prog.push_back(enc_b(13'd8, 2, 2, 0));
        prog.push_back(enc_i(12'h001, 0, 0, 15, 7'h13));
        prog.push_back(enc_b(13'd8, 2, 1, 4));
        prog.push_back(enc_i(12'h001, 0, 0, 16, 7'h13));
        prog.push_back(enc_b(13'd8, 2, 1, 5));
        prog.push_back(enc_i(12'h001, 0, 0, 17, 7'h13));
        prog.push_back(enc_i(12'h25D, 0, 0, 18, 7'h67));
        prog.push_back(enc_i(12'h001, 0, 0, 19, 7'h13));
        prog.push_back(enc_i(12'h002, 0, 0, 19, 7'h13));
        prog.push_back(enc_i(12'h009, 0, 0, 20, 7'h13));
        prog.push_back(enc_u(20'h00004, 22, 7'h37));
        prog.push_back(enc_i(12'h400, 22, 2, 21, 7'h03));
        prog.push_back(enc_i(12'h402, 0, 2, 23, 7'h03));
        load_prog();
        dut.memory.memory[32'h100] = 32'hCAFEF00D;
        pulse_reset(1);
        run(40);
        chk("sub", rg(3), 32'hFFFFFFF8);
        chk("and", rg(4), 32'h3);
        chk("or", rg(5), 32'hFFFFFFFB);
        chk("xor", rg(6), 32'hFFFFFFF8);
        chk("slt_t", rg(7), 32'd1);
        chk("slt_f", rg(8), 32'd0);
        chk("andi", rg(9), 32'hF0);
        chk("ori", rg(10), 32'h703);
        chk("xori", rg(11), 32'hFFFFFFFC);
        chk("slti", rg(12), 32'd1);
        chk("lui", rg(13), 32'h12345000);
        chk("auipc", rg(14), 32'h1234);
        chk("beq_skip", rg(15), 32'd0);
        chk("blt_skip", rg(16), 32'd0);
        chk("bge_fall", rg(17), 32'd1);
        chk("jalr_link", rg(18), 32'h254);
        chk("jalr_skip", rg(19), 32'd0);
        chk("jalr_tgt", rg(20), 32'd9);
        chk("lw_wrap", rg(21), 32'hCAFEF00D);
        chk("lw_misal", rg(23), 32'hCAFEF00D);

        // JAL then ECALL
        prog = '{32'h008000EF, enc_i(12'h009, 0, 0, 3, 7'h13), enc_i(12'h007, 0, 0, 2, 7'h13),
                 32'h00000073, enc_i(12'h001, 0, 0, 4, 7'h13)};
        load_prog();
        pulse_reset(1);
        run(1);
        chk("jal_link", rg(1), 32'h204);
        chk("jal_pc", dut.core.r_pc, 32'h208);
        run(2);
        chk("jal_tgt", rg(2), 32'd7);
        chk("jal_skip", rg(3), 32'd0);
        run(1);
`ifdef SOC_ILLEGAL_HALT_EN
        chk("ecall_pc", dut.core.r_pc, 32'h20C);
        chk("ecall_x4", rg(4), 32'd0);
`else
        chk("ecall_pc", dut.core.r_pc, 32'h214);
        chk("ecall_x4", rg(4), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
